// File: rtl/backend_gain_cal_ctrl.sv
// Sequencer for the analog backend: resets it, streams {gainA1,gainA2} frames, waits for ready
// and SAR-searches gainA1 from the VCO comparator. Optional feature macro: CAL_MAJORITY_EN.
module backend_gain_cal_ctrl #(
    parameter int CLK_DIV    = 4,
    parameter int G1_W       = 3,
    parameter int G2_W       = 2,
    parameter int RST_CYC    = 8,
    parameter int SETTLE_CYC = 16,
    parameter int RDY_TO     = 1023
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [G2_W-1:0] i_gainA2,
    input  logic            i_ready,
    input  logic            i_vco1_fast,
    output logic            o_resetbAll,
    output logic            o_sclk,
    output logic            o_sdout,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_timeout,
    output logic [G1_W-1:0] o_gainA1
);

    localparam int FRM_W   = G1_W + G2_W;
    localparam int M1      = (RDY_TO > 2 * CLK_DIV) ? RDY_TO : 2 * CLK_DIV;
    localparam int M2      = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
    localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(FRM_W + 1);
    localparam int K_W     = (G1_W > 1) ? $clog2(G1_W) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_RST, S_SHIFT, S_WAIT_RDY, S_SETTLE, S_SAMPLE, S_FINAL, S_DONE, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [G1_W-1:0]   gain_q, gain_d, gain_upd;
    logic [FRM_W-1:0]  word_q, word_d;
    logic              final_q, final_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              resetb_q, resetb_d;
    logic              decide, fast;
    logic              rdy_meta, rdy_sync, vco_meta, vco_sync;
`ifdef CAL_MAJORITY_EN
    logic [1:0]        sidx_q, sidx_d;
    logic [1:0]        votes_q, votes_d, votes_sum;
`endif

    // Two-flop synchronisers for the asynchronous backend flags
    always_ff @(posedge i_clk) begin
        rdy_meta <= i_ready;
        rdy_sync <= rdy_meta;
        vco_meta <= i_vco1_fast;
        vco_sync <= vco_meta;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_d     = bit_q;
        k_d       = k_q;
        gain_d    = gain_q;
        gain_upd  = gain_q;
        word_d    = word_q;
        final_d   = final_q;
        busy_d    = busy_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        resetb_d  = resetb_q;
        decide    = 1'b0;
        fast      = 1'b0;
`ifdef CAL_MAJORITY_EN
        sidx_d    = sidx_q;
        votes_d   = votes_q;
        votes_sum = votes_q + {1'b0, vco_sync};
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                cnt_d = '0;
                if (i_start) begin
                    state_d   = S_RST;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    resetb_d  = 1'b0;
                    final_d   = 1'b0;
                    gain_d    = G1_W'(1) << (G1_W - 1);
                    k_d       = K_W'(G1_W - 1);
                end
            end
            S_RST: begin
                if (cnt_q == CNT_W'(RST_CYC - 1)) begin
                    state_d  = S_SHIFT;
                    resetb_d = 1'b1;
                    cnt_d    = '0;
                    bit_d    = '0;
                    word_d   = {gain_q, i_gainA2};
                end
            end
            S_SHIFT: begin
                // One bit = CLK_DIV cycles sclk low then CLK_DIV cycles sclk high
                if (cnt_q == CNT_W'(2 * CLK_DIV - 1)) begin
                    cnt_d  = '0;
                    word_d = {word_q[FRM_W-2:0], 1'b0};
                    if (bit_q == BIT_W'(FRM_W - 1)) state_d = S_WAIT_RDY;
                    else                            bit_d   = bit_q + 1'b1;
                end
            end
            S_WAIT_RDY: begin
                if (rdy_sync) begin
                    cnt_d = '0;
                    if (final_q) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SETTLE;
                    end
                end else if (cnt_q == CNT_W'(RDY_TO - 1)) begin
                    state_d   = S_ERR;
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    state_d = S_SAMPLE;
                    cnt_d   = '0;
`ifdef CAL_MAJORITY_EN
                    sidx_d  = '0;
                    votes_d = '0;
`endif
                end
            end
            S_SAMPLE: begin
`ifdef CAL_MAJORITY_EN
                // Votes are taken at SAMPLE entry and every SETTLE_CYC cycles after
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    cnt_d  = '0;
                    sidx_d = sidx_q + 1'b1;
                end
                if (cnt_q == '0) begin
                    if (sidx_q == 2'd2) begin
                        decide = 1'b1;
                        fast   = (votes_sum >= 2'd2);
                    end else begin
                        votes_d = votes_sum;
                    end
                end
`else
                decide = 1'b1;
                fast   = vco_sync;
`endif
                if (decide) begin
                    cnt_d = '0;
                    if (fast) gain_upd[k_q] = 1'b0;
                    if (k_q != '0) begin
                        k_d             = k_q - 1'b1;
                        gain_upd[k_d]   = 1'b1;
                        state_d         = S_SHIFT;
                        bit_d           = '0;
                        word_d          = {gain_upd, i_gainA2};
                    end else begin
                        state_d = S_FINAL;
                    end
                    gain_d = gain_upd;
                end
            end
            S_FINAL: begin
                state_d = S_SHIFT;
                final_d = 1'b1;
                cnt_d   = '0;
                bit_d   = '0;
                word_d  = {gain_q, i_gainA2};
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q     <= '0;
            bit_q     <= '0;
            k_q       <= '0;
            gain_q    <= '0;
            final_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            resetb_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            k_q       <= k_d;
            gain_q    <= gain_d;
            final_q   <= final_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            resetb_q  <= resetb_d;
        end
    end

    // Frame word and vote tally are pure data; they are always reloaded before use
    always_ff @(posedge i_clk) begin
        word_q  <= word_d;
`ifdef CAL_MAJORITY_EN
        sidx_q  <= sidx_d;
        votes_q <= votes_d;
`endif
    end

    assign o_sclk      = (state_q == S_SHIFT) && (cnt_q >= CNT_W'(CLK_DIV));
    assign o_sdout     = (state_q == S_SHIFT) && word_q[FRM_W-1];
    assign o_resetbAll = resetb_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_timeout   = timeout_q;
    assign o_gainA1    = gain_q;

endmodule
